// File: rtl/lcd_wr_sequencer.sv
// HD44780 write sequencer: setup / EN pulse / hold / exec wait per byte, with a 1-deep holding slot.
// Optional macro LCD_INIT_EN adds a power-on wait and an autonomous 0x38/0x0C/0x01/0x06 init sequence.
module lcd_wr_sequencer #(
   parameter int unsigned T_AS_CYC   = 4,
   parameter int unsigned T_EN_CYC   = 25,
   parameter int unsigned T_H_CYC    = 2,
   parameter int unsigned T_EXEC_CYC = 1850,
   parameter int unsigned T_CLR_CYC  = 76000,
   parameter int unsigned T_PWR_CYC  = 2000000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_wr,
   input  logic [7:0]  i_data,
   input  logic        i_rs,
   input  logic        i_on,
   input  logic        i_ovr_clr,
   output logic [7:0]  o_lcd_data,
   output logic        o_lcd_rs,
   output logic        o_lcd_rw,
   output logic        o_lcd_en,
   output logic        o_lcd_on,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_overrun,
   output logic [31:0] o_status
);
   localparam int unsigned CW = $clog2(T_PWR_CYC + 1);

   typedef enum logic [2:0] {
      IDLE, SETUP, PULSE, HOLD, EXEC
`ifdef LCD_INIT_EN
      , PWR
`endif
   } state_t;

   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic [7:0]      data_q;
   logic            rs_q, en_q, on_q, done_q, ovr_q, slot_vld_q;
   logic [8:0]      slot_q;

   logic busy, cnt_end, exec_end, is_clr, init_more, init_pend, drain, hold_wr;

`ifdef LCD_INIT_EN
   logic       init_pend_q, init_cur_q;
   logic [2:0] init_idx_q;

   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      case (idx)
         2'd0:    init_cmd = 8'h38;
         2'd1:    init_cmd = 8'h0C;
         2'd2:    init_cmd = 8'h01;
         default: init_cmd = 8'h06;
      endcase
   endfunction

   assign init_pend = init_pend_q;
   assign init_more = init_cur_q && (init_idx_q < 3'd4);
`else
   assign init_pend = 1'b0;
   assign init_more = 1'b0;
`endif

   assign busy     = (state_q != IDLE);
   assign cnt_end  = (cnt_q == '0);
   assign exec_end = (state_q == EXEC) && cnt_end;
   assign is_clr   = !rs_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03);
   // The drain cycle hands the slot to the FSM, so a write there refills rather than overruns.
   assign drain    = exec_end && !init_more;
   assign hold_wr  = i_wr && !drain && (busy || init_pend);

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         data_q     <= '0;
         rs_q       <= 1'b0;
         en_q       <= 1'b0;
         on_q       <= 1'b0;
         done_q     <= 1'b0;
         ovr_q      <= 1'b0;
         slot_vld_q <= 1'b0;
         slot_q     <= '0;
`ifdef LCD_INIT_EN
         init_pend_q <= 1'b1;
         init_cur_q  <= 1'b0;
         init_idx_q  <= '0;
`endif
      end else begin
         on_q   <= i_on;
         done_q <= 1'b0;
         if (hold_wr && slot_vld_q)
            ovr_q <= 1'b1;
         else if (i_ovr_clr)
            ovr_q <= 1'b0;
         if (hold_wr && !slot_vld_q) begin
            slot_vld_q <= 1'b1;
            slot_q     <= {i_rs, i_data};
         end
         case (state_q)
            IDLE: begin
`ifdef LCD_INIT_EN
               if (init_pend_q) begin
                  init_pend_q <= 1'b0;
                  state_q     <= PWR;
                  cnt_q       <= CW'(T_PWR_CYC - 1);
               end else
`endif
               if (i_wr) begin
                  {rs_q, data_q} <= {i_rs, i_data};
                  state_q        <= SETUP;
                  cnt_q          <= CW'(T_AS_CYC - 1);
               end
            end
            SETUP: begin
               if (cnt_end) begin
                  state_q <= PULSE;
                  en_q    <= 1'b1;
                  cnt_q   <= CW'(T_EN_CYC - 1);
               end else
                  cnt_q <= cnt_q - 1'b1;
            end
            PULSE: begin
               if (cnt_end) begin
                  state_q <= HOLD;
                  en_q    <= 1'b0;
                  cnt_q   <= CW'(T_H_CYC - 1);
               end else
                  cnt_q <= cnt_q - 1'b1;
            end
            HOLD: begin
               if (cnt_end) begin
                  state_q <= EXEC;
                  cnt_q   <= is_clr ? CW'(T_CLR_CYC - 1) : CW'(T_EXEC_CYC - 1);
               end else
                  cnt_q <= cnt_q - 1'b1;
            end
            EXEC: begin
               if (!cnt_end)
                  cnt_q <= cnt_q - 1'b1;
`ifdef LCD_INIT_EN
               else if (init_more) begin
                  {rs_q, data_q} <= {1'b0, init_cmd(init_idx_q[1:0])};
                  init_idx_q     <= init_idx_q + 1'b1;
                  state_q        <= SETUP;
                  cnt_q          <= CW'(T_AS_CYC - 1);
               end
`endif
               else begin
                  state_q <= SETUP;
                  cnt_q   <= CW'(T_AS_CYC - 1);
`ifdef LCD_INIT_EN
                  done_q     <= !init_cur_q;
                  init_cur_q <= 1'b0;
`else
                  done_q  <= 1'b1;
`endif
                  if (slot_vld_q) begin
                     {rs_q, data_q} <= slot_q;
                     slot_vld_q     <= i_wr;
                     slot_q         <= {i_rs, i_data};
                  end else if (i_wr)
                     {rs_q, data_q} <= {i_rs, i_data};
                  else
                     state_q <= IDLE;
               end
            end
`ifdef LCD_INIT_EN
            PWR: begin
               if (cnt_end) begin
                  {rs_q, data_q} <= {1'b0, init_cmd(2'd0)};
                  init_idx_q     <= 3'd1;
                  init_cur_q     <= 1'b1;
                  state_q        <= SETUP;
                  cnt_q          <= CW'(T_AS_CYC - 1);
               end else
                  cnt_q <= cnt_q - 1'b1;
            end
`endif
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_lcd_data = data_q;
   assign o_lcd_rs   = rs_q;
   assign o_lcd_rw   = 1'b0;
   assign o_lcd_en   = en_q;
   assign o_lcd_on   = on_q;
   assign o_busy     = busy;
   assign o_done     = done_q;
   assign o_overrun  = ovr_q;
   assign o_status   = {busy, ovr_q, 22'b0, data_q};
endmodule

// File: doc/lcd_wr_sequencer.md
Name: lcd_wr_sequencer

Overview:
- Consumer side of the LSU LCD output register path.
- Takes single LCD write requests (data byte, RS, display-on) from the store path and drives the HD44780-style character LCD pins with correct setup, enable-pulse, hold and execution timing.
- Provides a busy/done/overrun status word for software polling through the input buffer region.
- Write-only to the LCD: RW is tied low and the LCD busy flag is never read.

Parameters:
- T_AS_CYC, 4: cycles RS/data are stable before EN rises (address setup).
- T_EN_CYC, 25: cycles EN is held high.
- T_H_CYC, 2: cycles RS/data are held after EN falls.
- T_EXEC_CYC, 1850: post-write wait for normal instructions and data writes (37 us at 50 MHz).
- T_CLR_CYC, 76000: post-write wait for clear/home instructions (1.52 ms at 50 MHz).
- T_PWR_CYC, 2000000: power-on wait, used only with LCD_INIT_EN.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous active-low reset
- i_wr  in  1  one-cycle write request
- i_data  in  8  LCD data/instruction byte, sampled with i_wr
- i_rs  in  1  register select (0 = instruction, 1 = data), sampled with i_wr
- i_on  in  1  display power enable
- i_ovr_clr  in  1  one-cycle clear of the sticky overrun flag
- o_lcd_data  out  8  LCD data bus
- o_lcd_rs  out  1  LCD RS
- o_lcd_rw  out  1  LCD RW, constant 0
- o_lcd_en  out  1  LCD EN
- o_lcd_on  out  1  LCD power
- o_busy  out  1  sequencer not in IDLE
- o_done  out  1  one-cycle pulse when a write's execution wait ends
- o_overrun  out  1  sticky: a request was dropped
- o_status  out  32  {o_busy, o_overrun, 22'b0, o_lcd_data}

Behaviour:
- Reset (async, i_rst=0):
  - All outputs are 0; state is IDLE; holding slot is empty.
  - The output register and counter are cleared immediately, mid-operation included. EN falls asynchronously.
- o_lcd_on is a register that follows i_on every cycle. It is independent of the FSM.
- FSM states are IDLE, SETUP, PULSE, HOLD, EXEC. Each non-IDLE state lasts exactly its parameter count, using one down-counter sized $clog2(T_PWR_CYC+1).
- IDLE:
  - i_wr latches {i_rs, i_data} into the output register. Next cycle enters SETUP.
  - o_lcd_data/o_lcd_rs change only on that latch.
- SETUP lasts T_AS_CYC cycles with EN=0, then goes to PULSE.
- PULSE lasts T_EN_CYC cycles with EN=1, then goes to HOLD.
- HOLD lasts T_H_CYC cycles with EN=0, then goes to EXEC.
- EXEC wait length:
  - T_CLR_CYC if latched RS=0 and data is 0x01, 0x02 or 0x03.
  - Otherwise T_EXEC_CYC.
- EXEC end:
  - On the cycle after EXEC ends, o_done=1 for one cycle.
  - If the slot is full, the slot is latched and SETUP is entered, so o_busy stays 1.
  - If the slot is empty, the FSM goes to IDLE and o_busy=0.
- Latency: a write accepted at cycle 0 gives o_done at cycle 1+T_AS+T_EN+T_H+T_wait. EN is high over cycles 1+T_AS through T_AS+T_EN.
- i_wr while busy, slot empty: the request is captured into the 1-entry slot.
- i_wr while busy, slot full: the request is dropped and o_overrun is set to 1.
- Simultaneous events:
  - i_wr in the same cycle the slot drains: the slot is refilled with the new request, with no overrun.
  - i_wr in the o_done cycle with the FSM entering IDLE: the request is accepted directly.
  - i_ovr_clr together with a new overrun: the overrun wins.

Optional Feature:
- LCD_INIT_EN defined:
  - After reset release, the sequencer waits T_PWR_CYC.
  - It then autonomously issues instructions 0x38, 0x0C, 0x01, 0x06 (RS=0), each with full timing and no o_done pulses.
  - o_busy=1 throughout. User writes during init obey the slot/overrun rules.
- LCD_INIT_EN undefined: IDLE immediately after reset and T_PWR_CYC is unused.

Test Plan:
Parameters for all tests: T_AS=2, T_EN=3, T_H=1, T_EXEC=5, T_CLR=20.
- Reset: assert i_rst=0 → all outputs 0, o_status=0. Release → o_busy stays 0 (macro off).
- Data write i_wr, data=0x41, rs=1 at cycle 0:
  - o_lcd_data=0x41 and rs=1 from cycle 1.
  - EN=1 only during cycles 3–5.
  - o_busy=1 during cycles 1–11.
  - o_done=1 at cycle 12, with o_busy=0.
- Clear instruction 0x01, rs=0 → EXEC lasts 20 cycles and o_done=1 at cycle 27. Repeat with 0x80 → o_done at cycle 12.
- Back-to-back 0x41, 0x42, 0x43 at cycles 0, 2, 4:
  - 0x42 is held and its SETUP starts at cycle 12, with o_busy continuously 1.
  - 0x43 sets o_overrun=1. i_ovr_clr clears it.
- i_wr at cycle 11 with the slot full (drain cycle) → the new byte follows, and o_overrun stays 0.
- Reset at cycle 4 (mid-PULSE) → EN=0 immediately and the slot is empty. After release, a new write sequences normally.
